// File: rtl/regfile_scoreboard.sv
// Register file with bypassed combinational reads and a per-register
// busy scoreboard. Two write ports (port 1 wins on collision), one issue
// port that marks a destination as pending, and a registered busy count.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_ready,
  input  logic                   wr0_en,
  input  logic [AW-1:0]          wr0_addr,
  input  logic [XLEN-1:0]        wr0_data,
  input  logic                   wr1_en,
  input  logic [AW-1:0]          wr1_addr,
  input  logic [XLEN-1:0]        wr1_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic [AW:0]            busy_cnt
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;
  logic [AW:0]      busy_cnt_r;
  logic             wr0_ok_s;
  logic             wr1_ok_s;
  logic             iss_ok_s;

  // Number of set bits in a busy vector.
  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int j = 0; j < DEPTH; j++) begin
      c = c + {{AW{1'b0}}, v[j]};
    end
    return c;
  endfunction

  // Writes and issues aimed at the hardwired zero register are dropped here,
  // so everything downstream can treat these strobes as fully qualified.
  assign wr0_ok_s = wr0_en && !(ZERO_EN && (wr0_addr == {AW{1'b0}}));
  assign wr1_ok_s = wr1_en && !(ZERO_EN && (wr1_addr == {AW{1'b0}}));
  assign iss_ok_s = iss_en && !(ZERO_EN && (iss_addr == {AW{1'b0}}));

  // Next busy vector: a write retires the pending result, a same-cycle issue
  // to the same register re-arms it (the newer producer wins).
  always_comb begin
    busy_nxt_s = {DEPTH{1'b0}};
    for (int j = 0; j < DEPTH; j++) begin
      busy_nxt_s[j] = (iss_ok_s && (iss_addr == AW'(j))) ||
                      (busy_r[j] &&
                       !(wr0_ok_s && (wr0_addr == AW'(j))) &&
                       !(wr1_ok_s && (wr1_addr == AW'(j))));
    end
  end

  // Storage, busy bits and busy count; reset discards same-cycle writes/issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        regs_r[j] <= {XLEN{1'b0}};
      end
      busy_r     <= {DEPTH{1'b0}};
      busy_cnt_r <= {(AW+1){1'b0}};
    end else begin
      if (wr0_ok_s) begin
        regs_r[wr0_addr] <= wr0_data;
      end
      // Issued after port 0 so that port 1 data lands on an address collision.
      if (wr1_ok_s) begin
        regs_r[wr1_addr] <= wr1_data;
      end
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= popcount(busy_nxt_s);
    end
  end

  assign busy_cnt = busy_cnt_r;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   a_s;
    logic [XLEN-1:0] d_s;
    logic            r_s;
    logic            z_s;
    logic            h0_s;
    logic            h1_s;

    assign a_s = rd_addr[i*AW +: AW];

    // Read port: zero register, then write-port-1 bypass, then port 0, then storage.
    always_comb begin
      z_s  = ZERO_EN && (a_s == {AW{1'b0}});
      h0_s = wr0_ok_s && (wr0_addr == a_s);
      h1_s = wr1_ok_s && (wr1_addr == a_s);
      if (z_s) begin
        d_s = {XLEN{1'b0}};
      end else if (h1_s) begin
        d_s = wr1_data;
      end else if (h0_s) begin
        d_s = wr0_data;
      end else begin
        d_s = regs_r[a_s];
      end
      r_s = z_s || h0_s || h1_s || !busy_r[a_s];
    end

    assign rd_data[i*XLEN +: XLEN] = d_s;
    assign rd_ready[i]             = r_s;
  end

endmodule
